// File: rtl/pipe_stage_elastic_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic inter-stage pipeline registers.
//   - occ_e      : occupancy state encoding (number of held bundles)
//   - *_W / *_NOP: bundle widths and empty-slot payloads for each pipeline
//                  boundary, meant to be passed as NOP_VALUE so that an empty
//                  slot decodes as a harmless instruction downstream.
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // IF/ID: {pc[31:0], instr[31:0]}; the empty slot carries addi x0,x0,0.
    localparam int IFID_W = 64;
    localparam logic [IFID_W-1:0] IFID_NOP = {32'h0000_0000, 32'h0000_0013};

    // ID/EX: operands, immediate, pc and control; all-zero control means
    // no RegWrite / MemWrite / hlt.
    localparam int IDEX_W = 128;
    localparam logic [IDEX_W-1:0] IDEX_NOP = '0;

    // EX/MEM: alu result, store data, destination and control.
    localparam int EXMEM_W = 96;
    localparam logic [EXMEM_W-1:0] EXMEM_NOP = '0;

    // MEM/WB: writeback value, destination and RegWrite.
    localparam int MEMWB_W = 64;
    localparam logic [MEMWB_W-1:0] MEMWB_NOP = '0;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic_if
//   One valid/ready channel carrying a WIDTH-bit bundle.
//   Signals : valid (source -> sink), ready (sink -> source), data (source -> sink)
//   Modports: master = producing side, slave = consuming side.
// ---------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that sticks at all-ones. Clear has priority over
//   increment.
//   Ports: clk, rst (async, active-high), i_inc, i_clr, o_count[W-1:0]
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic pipeline boundary register with valid/ready handshake, optional
//   2-entry skid buffer, flush-to-bubble and a saturating stall counter.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     i_up (slave)  : upstream channel (valid/data in, ready out)
//     o_dn (master) : downstream channel (valid/data out, ready in);
//                     data is NOP_VALUE whenever valid is low
//     i_flush       : drop every held bundle and the one offered this cycle
//     i_stall_clr   : clear the stall counter
//     o_occupancy   : number of held bundles (0..2, 0..1 without skid)
//     o_stall_cnt   : saturating count of cycles with valid & ~ready
// ---------------------------------------------------------------------------
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               STALL_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_elastic_if.slave  i_up,
    pipe_stage_elastic_if.master o_dn,
    input  logic                 i_flush,
    input  logic                 i_stall_clr,
    output logic [1:0]           o_occupancy,
    output logic [STALL_W-1:0]   o_stall_cnt
);

    occ_e             r_state;
    occ_e             w_state_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] w_main_next;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_skid_next;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;

    assign w_accept = i_up.valid & w_in_ready;
    assign w_pop    = r_out_valid & o_dn.ready;

    // Upstream ready: registered with a skid entry, otherwise a direct
    // "slot free or being drained" term.
    generate
        if (SKID != 0) begin : g_skid_ready
            logic r_in_ready;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != OCC_TWO);
                end
            end
            assign w_in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign w_in_ready = ~r_out_valid | o_dn.ready;
        end
    endgenerate

    // Main register always holds what is shown downstream, so it is reloaded
    // with NOP_VALUE whenever the stage empties; out_data needs no mux.
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main_data;
        w_skid_next  = r_skid_data;
        if (i_flush) begin
            w_state_next = OCC_EMPTY;
            w_main_next  = NOP_VALUE;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = OCC_ONE;
                        w_main_next  = i_up.data;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_next = i_up.data;
                    end else if (w_accept && (SKID != 0)) begin
                        // Downstream stalled: park the newcomer behind main.
                        w_state_next = OCC_TWO;
                        w_skid_next  = i_up.data;
                    end else if (w_pop) begin
                        w_state_next = OCC_EMPTY;
                        w_main_next  = NOP_VALUE;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_state_next = OCC_ONE;
                        w_main_next  = r_skid_data;
                    end
                end
                default: begin
                    w_state_next = OCC_EMPTY;
                    w_main_next  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OCC_EMPTY;
            r_out_valid <= 1'b0;
            r_main_data <= NOP_VALUE;
            r_skid_data <= NOP_VALUE;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != OCC_EMPTY);
            r_main_data <= w_main_next;
            r_skid_data <= w_skid_next;
        end
    end

    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (r_out_valid & ~o_dn.ready),
        .i_clr   (i_stall_clr),
        .o_count (o_stall_cnt)
    );

    assign i_up.ready  = w_in_ready;
    assign o_dn.valid  = r_out_valid;
    assign o_dn.data   = r_main_data;
    assign o_occupancy = r_state;

`ifndef SYNTHESIS
    // Upstream must hold its bundle while it is refused (a flush releases it).
    a_in_data_stable: assert property (
        @(posedge clk) disable iff (rst)
        (i_up.valid && !w_in_ready && !i_flush) |=> (!i_up.valid || $stable(i_up.data))
    );

    a_occupancy_max: assert property (
        @(posedge clk) disable iff (rst)
        (o_occupancy <= 2'd2)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//   Three builds side by side: [0] SKID=1 STALL_W=16, [1] SKID=0 STALL_W=16,
//   [2] SKID=1 STALL_W=4. Each is compared every cycle against a FIFO model
//   (a queue of capacity 2 or 1 plus a saturating integer stall count).
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int          N   = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] s_valid;
    logic [N-1:0] s_out_ready;
    logic [N-1:0] s_flush;
    logic [N-1:0] s_clr;
    logic [31:0]  s_data [N];

    logic [N-1:0] o_valid;
    logic [N-1:0] o_in_ready;
    logic [31:0]  o_data  [N];
    logic [1:0]   o_occ   [N];
    logic [15:0]  o_stall [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            localparam int SK = (gi == 1) ? 0 : 1;
            localparam int SW = (gi == 2) ? 4 : 16;
            logic [SW-1:0] w_stall;
            logic [1:0]    w_occ;
            pipe_stage_elastic_if #(.WIDTH(32)) up ();
            pipe_stage_elastic_if #(.WIDTH(32)) dn ();

            assign up.valid       = s_valid[gi];
            assign up.data        = s_data[gi];
            assign dn.ready       = s_out_ready[gi];
            assign o_in_ready[gi] = up.ready;
            assign o_valid[gi]    = dn.valid;
            assign o_data[gi]     = dn.data;
            assign o_occ[gi]      = w_occ;
            assign o_stall[gi]    = 16'(w_stall);

            pipe_stage_elastic #(
                .WIDTH     (32),
                .SKID      (SK),
                .NOP_VALUE (NOP),
                .STALL_W   (SW)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .i_up        (up),
                .o_dn        (dn),
                .i_flush     (s_flush[gi]),
                .i_stall_clr (s_clr[gi]),
                .o_occupancy (w_occ),
                .o_stall_cnt (w_stall)
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    logic [31:0]  m_q [N][$];
    int           m_stall [N];
    int           m_max   [N] = '{65535, 65535, 15};
    bit           m_skid  [N] = '{1'b1, 1'b0, 1'b1};
    logic [N-1:0] hold;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_rdy(input int k);
        if (m_skid[k]) return m_q[k].size() < 2;
        return (m_q[k].size() == 0) || s_out_ready[k];
    endfunction

    // A refused bundle keeps its data while valid stays high.
    task automatic drive(input int k, input bit v, input logic [31:0] d,
                         input bit ordy, input bit fl, input bit clr);
        s_valid[k] = v;
        if (!(hold[k] && v)) s_data[k] = d;
        s_out_ready[k] = ordy;
        s_flush[k]     = fl;
        s_clr[k]       = clr;
    endtask

    task automatic drive_all(input bit v, input logic [31:0] d,
                             input bit ordy, input bit fl, input bit clr);
        for (int k = 0; k < N; k++) drive(k, v, d, ordy, fl, clr);
    endtask

    // Called just after a falling edge with inputs applied: check, step the
    // model across the coming rising edge, wait for the next falling edge.
    task automatic cycle();
        #1;
        for (int k = 0; k < N; k++) begin
            bit ov;
            ov = (m_q[k].size() > 0);
            chk($sformatf("d%0d_out_valid", k), 64'(o_valid[k]), 64'(ov));
            chk($sformatf("d%0d_out_data", k), 64'(o_data[k]), 64'(ov ? m_q[k][0] : NOP));
            chk($sformatf("d%0d_in_ready", k), 64'(o_in_ready[k]), 64'(model_rdy(k)));
            chk($sformatf("d%0d_occupancy", k), 64'(o_occ[k]), 64'(m_q[k].size()));
            chk($sformatf("d%0d_stall_cnt", k), 64'(o_stall[k]), 64'(m_stall[k]));
        end
        for (int k = 0; k < N; k++) begin
            bit rdy, acc, pop;
            rdy     = model_rdy(k);
            acc     = s_valid[k] && rdy;
            pop     = (m_q[k].size() > 0) && s_out_ready[k];
            hold[k] = s_valid[k] && !rdy && !s_flush[k];
            if (s_clr[k]) m_stall[k] = 0;
            else if ((m_q[k].size() > 0) && !s_out_ready[k] && (m_stall[k] < m_max[k]))
                m_stall[k]++;
            if (k == 0 && pop) $display("xfer d0 data=%08h", m_q[0][0]);
            if (s_flush[k]) begin
                m_q[k].delete();
            end else begin
                if (pop) void'(m_q[k].pop_front());
                if (acc) m_q[k].push_back(s_data[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            s_valid[k] = 1'b0; s_out_ready[k] = 1'b0; s_flush[k] = 1'b0;
            s_clr[k] = 1'b0; s_data[k] = '0; hold[k] = 1'b0; m_stall[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();

        // streaming 1,2,3,... with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            drive_all(1'b1, 32'(i), 1'b1, 1'b0, 1'b0); cycle();
        end
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); repeat (2) cycle();

        // backpressure: A, B, C against a stalled consumer, then drain
        drive_all(1'b1, 32'hA0A0_0001, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b1, 32'hB0B0_0002, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b1, 32'hC0C0_0003, 1'b0, 1'b0, 1'b0); repeat (3) cycle();
        drive_all(1'b1, 32'hC0C0_0003, 1'b1, 1'b0, 1'b0); repeat (2) cycle();
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); repeat (4) cycle();

        // flush with two held and a third offered
        drive_all(1'b1, 32'hA1A1_0011, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b1, 32'hB1B1_0012, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b1, 32'hC1C1_0013, 1'b0, 1'b1, 1'b0); cycle();
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); repeat (2) cycle();

        // stall counter saturation, then clear during a stall cycle
        drive_all(1'b1, 32'hE0E0_0020, 1'b0, 1'b0, 1'b0); repeat (22) cycle();
        drive_all(1'b1, 32'hE0E0_0020, 1'b0, 1'b0, 1'b1); cycle();
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); repeat (4) cycle();

        // asynchronous reset between edges with the stage full
        drive_all(1'b1, 32'hA2A2_0031, 1'b0, 1'b0, 1'b0); cycle();
        drive_all(1'b1, 32'hB2B2_0032, 1'b0, 1'b0, 1'b0); cycle();
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("d%0d_rst_out_valid", k), 64'(o_valid[k]), 64'(0));
            chk($sformatf("d%0d_rst_out_data", k), 64'(o_data[k]), 64'(NOP));
            chk($sformatf("d%0d_rst_occupancy", k), 64'(o_occ[k]), 64'(0));
            chk($sformatf("d%0d_rst_stall_cnt", k), 64'(o_stall[k]), 64'(0));
            chk($sformatf("d%0d_rst_in_ready", k), 64'(o_in_ready[k]), 64'(1));
            m_q[k].delete();
            m_stall[k] = 0;
            hold[k]    = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        drive_all(1'b1, 32'hD0D0_0040, 1'b1, 1'b0, 1'b0); cycle();
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); repeat (2) cycle();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < N; k++) begin
                drive(k, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
